fint2float: RTL and testbench

//  - Converts a 32-bit two's-complement integer to IEEE-754 single precision (sign/exp/frac fields).
//  - Inverse of the float-to-int rounder. Round-to-nearest-even; reports zero and inexact.
//  - Multi-cycle en/ready handshake, iterative normalisation; sits in the FPU execute stage beside fround.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fint2float_if.sv | 24 ++
 rtl/fi2f_lzc.sv | 20 ++
 rtl/fint2float.sv | 143 ++++++++++++++
 tb/tb_fint2float.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and constants for the integer-to-float converter
package fpu_pkg;

    localparam int OPERAND_WIDTH  = 32;
    localparam int EXPONENT_WIDTH = 8;
    localparam int FRACTION_WIDTH = 23;

    localparam logic [EXPONENT_WIDTH-1:0] EXP_BIAS    = 8'b0111_1111;
    // Exponent of a value whose leading one sits in bit 31 of the magnitude.
    localparam logic [EXPONENT_WIDTH-1:0] INT_MSB_EXP = EXP_BIAS + 8'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fpu_state_e;

    typedef struct packed {
        logic                      sign;
        logic [EXPONENT_WIDTH-1:0] exp;
        logic [FRACTION_WIDTH-1:0] frac;
    } float_t;

    // Magnitude of a two's-complement word; 0x8000_0000 maps onto itself as unsigned 2^31.
    function automatic logic [OPERAND_WIDTH-1:0] abs_int(input logic [OPERAND_WIDTH-1:0] v);
        return v[OPERAND_WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/fint2float_if.sv
// rtl/fint2float_if.sv - request/result bundle between the execute stage and fint2float
interface fint2float_if;
    import fpu_pkg::*;

    logic                      fi2f_en_i;
    logic [OPERAND_WIDTH-1:0]  fi2f_int_i;
    logic                      fi2f_sign_o;
    logic [EXPONENT_WIDTH-1:0] fi2f_exp_o;
    logic [FRACTION_WIDTH-1:0] fi2f_frac_o;
    logic                      fi2f_inexact_o;
    logic                      fi2f_zero_o;
    logic                      fi2f_ready_o;

    modport master (
        output fi2f_en_i, fi2f_int_i,
        input  fi2f_sign_o, fi2f_exp_o, fi2f_frac_o, fi2f_inexact_o, fi2f_zero_o, fi2f_ready_o
    );

    modport slave (
        input  fi2f_en_i, fi2f_int_i,
        output fi2f_sign_o, fi2f_exp_o, fi2f_frac_o, fi2f_inexact_o, fi2f_zero_o, fi2f_ready_o
    );

endinterface

// File: rtl/fi2f_lzc.sv
// rtl/fi2f_lzc.sv - combinational 32-bit leading-zero counter (32 for an all-zero word)
module fi2f_lzc (
    input  logic [31:0] value_i,
    output logic [5:0]  count_o
);

    // Scan from the MSB down and keep the position of the first one found.
    always_comb begin
        logic found;
        count_o = 6'd32;
        found   = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && value_i[i]) begin
                count_o = 6'(31 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fint2float.sv
// rtl/fint2float.sv - signed 32-bit integer to IEEE-754 single, round-to-nearest-even; FI2F_FAST_NORM_EN selects one-cycle normalisation
module fint2float
    import fpu_pkg::*;
(
    input logic           fpu_clk,
    input logic           fpu_rst,
    fint2float_if.slave   bus
);

    fpu_state_e               state_q, state_d;
    logic                     in_sign_q, in_sign_d;
    logic [OPERAND_WIDTH-1:0] mag_q, mag_d;
    logic [5:0]               lz_q, lz_d;
    float_t                   res_q, res_d;
    logic                     inexact_q, inexact_d;
    logic                     zero_q, zero_d;
    logic                     ready_q, ready_d;

    logic [FRACTION_WIDTH-1:0] trunc_frac;
    logic                      guard_bit;
    logic                      sticky_bit;
    logic                      round_up;
    logic [FRACTION_WIDTH:0]   frac_sum;
    logic [EXPONENT_WIDTH-1:0] exp_pre;
    logic [EXPONENT_WIDTH-1:0] exp_rnd;

`ifdef FI2F_FAST_NORM_EN
    logic [5:0] lzc_cnt;

    fi2f_lzc u_lzc (
        .value_i (mag_q),
        .count_o (lzc_cnt)
    );
`endif

    // Rounding datapath on the normalised magnitude; a fraction carry-out bumps the exponent.
    always_comb begin
        trunc_frac = mag_q[30:8];
        guard_bit  = mag_q[7];
        sticky_bit = |mag_q[6:0];
        round_up   = guard_bit & (sticky_bit | trunc_frac[0]);
        frac_sum   = {1'b0, trunc_frac} + {{FRACTION_WIDTH{1'b0}}, round_up};
        exp_pre    = INT_MSB_EXP - {2'b00, lz_q};
        exp_rnd    = exp_pre + {{(EXPONENT_WIDTH-1){1'b0}}, frac_sum[FRACTION_WIDTH]};
    end

    // Next-state and next-output logic; results only change on entry to DONE.
    always_comb begin
        state_d   = state_q;
        in_sign_d = in_sign_q;
        mag_d     = mag_q;
        lz_d      = lz_q;
        res_d     = res_q;
        inexact_d = inexact_q;
        zero_d    = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.fi2f_en_i) begin
                    in_sign_d = bus.fi2f_int_i[OPERAND_WIDTH-1];
                    mag_d     = abs_int(bus.fi2f_int_i);
                    lz_d      = 6'd0;
                    state_d   = NORM;
                end
            end
            NORM: begin
                if (!bus.fi2f_en_i) begin
                    state_d = IDLE;
                end else if (mag_q == '0) begin
                    res_d     = '0;
                    zero_d    = 1'b1;
                    inexact_d = 1'b0;
                    state_d   = DONE;
`ifdef FI2F_FAST_NORM_EN
                end else begin
                    mag_d   = mag_q << lzc_cnt;
                    lz_d    = lzc_cnt;
                    state_d = ROUND;
                end
`else
                end else if (mag_q[OPERAND_WIDTH-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    lz_d  = lz_q + 6'd1;
                end
`endif
            end
            ROUND: begin
                if (!bus.fi2f_en_i) begin
                    state_d = IDLE;
                end else begin
                    res_d.sign = in_sign_q;
                    res_d.exp  = exp_rnd;
                    res_d.frac = frac_sum[FRACTION_WIDTH-1:0];
                    inexact_d  = guard_bit | sticky_bit;
                    zero_d     = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Holding en keeps the result presented; no new operand is taken.
                if (!bus.fi2f_en_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge fpu_clk) begin
        if (fpu_rst) begin
            state_q   <= IDLE;
            in_sign_q <= 1'b0;
            mag_q     <= '0;
            lz_q      <= '0;
            res_q     <= '0;
            inexact_q <= 1'b0;
            zero_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_sign_q <= in_sign_d;
            mag_q     <= mag_d;
            lz_q      <= lz_d;
            res_q     <= res_d;
            inexact_q <= inexact_d;
            zero_q    <= zero_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.fi2f_sign_o    = res_q.sign;
    assign bus.fi2f_exp_o     = res_q.exp;
    assign bus.fi2f_frac_o    = res_q.frac;
    assign bus.fi2f_inexact_o = inexact_q;
    assign bus.fi2f_zero_o    = zero_q;
    assign bus.fi2f_ready_o   = ready_q;

endmodule

// File: tb/tb_fint2float.sv
// tb/tb_fint2float.sv - scoreboard bench for fint2float with directed vectors
module tb_fint2float;

    logic fpu_clk = 1'b0;
    logic fpu_rst = 1'b1;

    fint2float_if bus ();

    fint2float dut (
        .fpu_clk (fpu_clk),
        .fpu_rst (fpu_rst),
        .bus     (bus.slave)
    );

    always #5 fpu_clk = ~fpu_clk;

    int cyc = 0;
    always @(posedge fpu_clk) cyc <= cyc + 1;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        inexact;
        logic        zero;
        int          lat;
        int          start;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of ready is matched against the oldest expected result.
    logic prev_ready = 1'b0;
    always @(negedge fpu_clk) begin
        exp_t e;
        if (bus.fi2f_ready_o && !prev_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sign",    {31'd0, bus.fi2f_sign_o},    {31'd0, e.sign});
                check("exp",     {24'd0, bus.fi2f_exp_o},     {24'd0, e.exp});
                check("frac",    {9'd0,  bus.fi2f_frac_o},    {9'd0,  e.frac});
                check("inexact", {31'd0, bus.fi2f_inexact_o}, {31'd0, e.inexact});
                check("zero",    {31'd0, bus.fi2f_zero_o},    {31'd0, e.zero});
                check("latency", cyc - e.start + 1, e.lat);
            end
        end
        prev_ready = bus.fi2f_ready_o;
    end

    task automatic convert(input logic [31:0] v, input logic s, input logic [7:0] ex,
                           input logic [22:0] fr, input logic inx, input logic z, input int lz);
        exp_t e;
        int   t;
        @(negedge fpu_clk);
        bus.fi2f_en_i  = 1'b1;
        bus.fi2f_int_i = v;
        e.sign    = s;
        e.exp     = ex;
        e.frac    = fr;
        e.inexact = inx;
        e.zero    = z;
`ifdef FI2F_FAST_NORM_EN
        e.lat     = z ? 2 : 3;
`else
        e.lat     = z ? 2 : 3 + lz;
`endif
        e.start   = cyc + 1;
        sb.push_back(e);
        t = 0;
        do begin
            @(negedge fpu_clk);
            t++;
        end while (!bus.fi2f_ready_o && t < 60);
        if (!bus.fi2f_ready_o) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.fi2f_en_i = 1'b0;
            @(negedge fpu_clk);
        end else begin
            repeat (2) @(negedge fpu_clk);
            check("done_hold_ready", {31'd0, bus.fi2f_ready_o}, 32'd1);
            bus.fi2f_en_i = 1'b0;
            @(negedge fpu_clk);
            check("ready_drop", {31'd0, bus.fi2f_ready_o}, 32'd0);
            check("exp_hold",   {24'd0, bus.fi2f_exp_o}, {24'd0, ex});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        bus.fi2f_en_i  = 1'b0;
        bus.fi2f_int_i = '0;
        repeat (3) @(negedge fpu_clk);
        fpu_rst = 1'b0;
        @(negedge fpu_clk);
        check("rst_outputs", {bus.fi2f_sign_o, bus.fi2f_exp_o, bus.fi2f_frac_o}, 32'd0);
        check("rst_flags", {29'd0, bus.fi2f_inexact_o, bus.fi2f_zero_o, bus.fi2f_ready_o}, 32'd0);

        //       value          sign  exp    frac        inx   zero  lz
        convert(32'd1,          1'b0, 8'h7F, 23'h000000, 1'b0, 1'b0, 31);
        convert(32'hFFFF_FFFF,  1'b1, 8'h7F, 23'h000000, 1'b0, 1'b0, 31);
        convert(32'h7FFF_FFFF,  1'b0, 8'h9E, 23'h000000, 1'b1, 1'b0, 1);
        convert(32'd16777217,   1'b0, 8'h97, 23'h000000, 1'b1, 1'b0, 7);
        convert(32'd16777219,   1'b0, 8'h97, 23'h000002, 1'b1, 1'b0, 7);
        convert(32'h8000_0000,  1'b1, 8'h9E, 23'h000000, 1'b0, 1'b0, 0);
        convert(32'd0,          1'b0, 8'h00, 23'h000000, 1'b0, 1'b1, 0);
        convert(32'd3,          1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 30);
        convert(32'hFFFF_FFFB,  1'b1, 8'h81, 23'h200000, 1'b0, 1'b0, 29);
        convert(32'h1234_5678,  1'b0, 8'h9B, 23'h11A2B4, 1'b1, 1'b0, 3);

        // Abort: en dropped two cycles into a conversion of 1; no result, outputs keep last value.
        @(negedge fpu_clk);
        bus.fi2f_en_i  = 1'b1;
        bus.fi2f_int_i = 32'd1;
        repeat (2) @(negedge fpu_clk);
        bus.fi2f_en_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge fpu_clk);
            if (bus.fi2f_ready_o) seen = 1;
        end
        check("abort_no_ready", seen, 0);
        check("abort_exp_hold",  {24'd0, bus.fi2f_exp_o},  32'h9B);
        check("abort_frac_hold", {9'd0,  bus.fi2f_frac_o}, 32'h11A2B4);

        // Reset pulse mid-conversion clears every output.
        @(negedge fpu_clk);
        bus.fi2f_en_i  = 1'b1;
        bus.fi2f_int_i = 32'd1;
        repeat (2) @(negedge fpu_clk);
        fpu_rst       = 1'b1;
        bus.fi2f_en_i = 1'b0;
        @(negedge fpu_clk);
        fpu_rst = 1'b0;
        check("midrst_outputs", {bus.fi2f_sign_o, bus.fi2f_exp_o, bus.fi2f_frac_o}, 32'd0);
        check("midrst_flags", {29'd0, bus.fi2f_inexact_o, bus.fi2f_zero_o, bus.fi2f_ready_o}, 32'd0);

        convert(32'h7FFF_FFFF,  1'b0, 8'h9E, 23'h000000, 1'b1, 1'b0, 1);

        repeat (3) @(negedge fpu_clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
